log_subtb_serial: RTL and testbench
===================================

Name: log_subtb_serial

Overview:
- Linear-to-log converter for the ADPCM encoder path; it is the inverse of the log-to-linear ANTILOG block.
- Takes the 16-bit two's-complement difference signal D and the 13-bit scale factor Y.
- Produces the G.726 LOG outputs DL (log2 magnitude) and DS (sign), plus the SUBTB output DLN = DL − (Y>>2) that feeds the quantizer.
- Normalization is iterative, one bit-shift per clock, behind a start/done handshake. This lets the encoder time-share one converter across channels.

Parameters:
- None. All widths are fixed by G.726.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous reset, active-high.
- start  input  1  request a conversion; sampled only when ready=1.
- D  input  16  difference signal, two's complement; sampled with start.
- Y  input  13  quantizer scale factor, unsigned; sampled with start.
- ready  output  1  high in IDLE and DONE; the block accepts start.
- done  output  1  one-cycle pulse: DL/DS/DLN are valid.
- DL  output  11  log2 magnitude, EXP[3:0] followed by MANT[6:0].
- DS  output  1  sign of D.
- DLN  output  12  normalized log difference, modulo 4096.

Behaviour:
- Reset: clk and reset are as stated above (one clock, synchronous active-high reset). Reset forces state=IDLE, ready=1, done=0, DL=0, DS=0, DLN=0, and clears internal registers. Reset wins over start in the same cycle. Reset during NORM aborts the conversion; no done is produced.
- States: IDLE, NORM, DONE.
- IDLE or DONE with start=1:
  - DS_r <= D[15].
  - DQM <= D[15] ? (65536−D) & 32767 : D & 32767, held in a 15-bit shift register SR.
  - EXP_r <= 14; YS_r <= Y[12:2].
  - Next state NORM; ready=0.
- IDLE or DONE with start=0: DONE → IDLE; IDLE stays IDLE.
- NORM, each cycle:
  - If SR[14]=1 or EXP_r=0, then capture DL <= {EXP_r, SR[13:7]}, DS <= DS_r, DLN <= ({1'b0,DL_next} − {1'b0,YS_r}) mod 4096, and go to DONE.
  - Otherwise SR <= SR<<1 and EXP_r <= EXP_r−1.
  - start is ignored in NORM.
- DONE: done=1 for exactly this one cycle.
- Output holding: DL/DS/DLN hold until the next completion or reset.
- Back-to-back: start asserted in DONE begins a new conversion with no idle cycle.
- Latency: with start accepted at cycle T and e = MSB position of DQM (e=0 when DQM=0), done=1 at cycle T+2+(14−e). Range is T+2 to T+16.
- Zero magnitude: DQM=0 gives EXP=0, MANT=0, DL=0 after 14 shifts. D=0x8000 gives DQM=0, DS=1.
- MANT is the 7 bits below the leading one, zero-filled. This is bit-exact to G.726 LOG: MANT = ((DQM<<7)>>EXP) & 127.
- DLN arithmetic: 12-bit wrap, so a negative result appears in two's complement as in SUBTB.

Test Plan:
- Reset, then start with D=0x4000, Y=0 at T → done at T+2 only; DL=0x700, DS=0, DLN=0x700; ready low at T+1 only.
- D=0x0300, Y=544 at T → done at T+7; DL=0x4C0, DS=0, DLN=0x438.
- D=0xFFFF, Y=0x1FFF → done at T+16; DL=0x000, DS=1, DLN=0x801. D=0x8000 → DL=0x000, DS=1, done at T+16.
- Back-to-back: start held high continuously with D=0x4000 → done every 2 cycles, with ready=1 on done cycles. start pulses during NORM are ignored; outputs are unchanged until the next done.
- reset asserted mid-NORM during a D=0x0001 conversion → next cycle IDLE, all outputs 0, no done. A following start with D=0x2000 → DL=0x680, done at T+3.
- Vector regression: replay the G.726 C-model dq/dl/ds/dln vectors for µ-law and A-law at 16/24/32/40 kb/s, using the same files as the ANTILOG tests. Check every DL/DS/DLN on done; zero mismatches required.

Source files
------------

// File: rtl/log_subtb_serial.sv
// Linear-to-log converter (G.726 LOG) with SUBTB subtraction, serial normalizer.
// One left shift per clock until the leading one reaches bit 14 or the
// exponent runs out; a start/done handshake lets several channels share it.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// NORM  | shifting magnitude left one bit per clock, ready=0
// DONE  | results just captured, done=1 for this cycle, ready=1
module log_subtb_serial (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] D,
  input  logic [12:0] Y,
  output logic        ready,
  output logic        done,
  output logic [10:0] DL,
  output logic        DS,
  output logic [11:0] DLN
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [14:0] r_sr;
  logic [3:0]  r_exp;
  logic        r_ds_pend;
  logic [10:0] r_ys;
  logic [10:0] r_dl;
  logic        r_ds;
  logic [11:0] r_dln;

  logic [14:0] w_mag;
  logic        w_norm_done;
  logic [10:0] w_dl_next;
  logic [11:0] w_dln_next;
  logic        w_accept;

  // Magnitude of D truncated to 15 bits; 0x8000 folds to zero as in G.726.
  assign w_mag       = D[15] ? 15'(16'd0 - D) : D[14:0];
  assign w_norm_done = r_sr[14] | (r_exp == 4'd0);
  assign w_dl_next   = {r_exp, r_sr[13:7]};
  assign w_dln_next  = {1'b0, w_dl_next} - {1'b0, r_ys};
  assign w_accept    = (r_state != NORM) && start;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    ready        = 1'b1;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = NORM;
      end
      NORM: begin
        ready = 1'b0;
        if (w_norm_done) w_state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_state_next = NORM;
        else       w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand load, normalizing shift, and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr      <= '0;
      r_exp     <= '0;
      r_ds_pend <= 1'b0;
      r_ys      <= '0;
      r_dl      <= '0;
      r_ds      <= 1'b0;
      r_dln     <= '0;
    end else if (w_accept) begin
      r_sr      <= w_mag;
      r_exp     <= 4'd14;
      r_ds_pend <= D[15];
      r_ys      <= 11'(Y >> 2);
    end else if (r_state == NORM) begin
      if (w_norm_done) begin
        r_dl  <= w_dl_next;
        r_ds  <= r_ds_pend;
        r_dln <= w_dln_next;
      end else begin
        r_sr  <= {r_sr[13:0], 1'b0};
        r_exp <= r_exp - 4'd1;
      end
    end
  end

  assign DL  = r_dl;
  assign DS  = r_ds;
  assign DLN = r_dln;

endmodule

// File: tb/tb_log_subtb_serial.sv
// Bench for log_subtb_serial: arithmetic reference model checked every cycle,
// plus hand-computed directed vectors.
module tb_log_subtb_serial;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] D;
  logic [12:0] Y;
  logic        ready;
  logic        done;
  logic [10:0] DL;
  logic        DS;
  logic [11:0] DLN;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int          m_cnt  = 0;
  bit          m_done = 1'b0;
  logic [10:0] m_dl   = '0;
  logic        m_ds   = 1'b0;
  logic [11:0] m_dln  = '0;
  logic [10:0] p_dl   = '0;
  logic        p_ds   = 1'b0;
  logic [11:0] p_dln  = '0;

  log_subtb_serial dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .D     (D),
    .Y     (Y),
    .ready (ready),
    .done  (done),
    .DL    (DL),
    .DS    (DS),
    .DLN   (DLN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // G.726 LOG + SUBTB from the arithmetic definition.
  task automatic ref_log(input logic [15:0] d, input logic [12:0] y,
                         output logic [10:0] dl, output logic ds,
                         output logic [11:0] dln, output int lat);
    int dqm, e, mant, dli;
    dqm = d[15] ? ((65536 - int'(d)) & 32767) : (int'(d) & 32767);
    e = 0;
    for (int b = 0; b < 15; b++) if (dqm[b]) e = b;
    mant = ((dqm << 7) >> e) & 127;
    dli  = (e << 7) | mant;
    dl   = 11'(dli);
    ds   = d[15];
    dln  = 12'((dli - (int'(y) >> 2)) & 4095);
    lat  = 2 + (14 - e);
  endtask

  task automatic model_update();
    int lat;
    if (reset) begin
      m_cnt = 0; m_done = 1'b0;
      m_dl = '0; m_ds = 1'b0; m_dln = '0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      m_done = (m_cnt == 0);
      if (m_done) begin
        m_dl = p_dl; m_ds = p_ds; m_dln = p_dln;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        ref_log(D, Y, p_dl, p_ds, p_dln, lat);
        m_cnt = lat - 1;
      end
    end
  endtask

  task automatic compare_all();
    check("ready", int'(ready), int'(m_cnt == 0));
    check("done",  int'(done),  int'(m_done));
    check("DL",    int'(DL),    int'(m_dl));
    check("DS",    int'(DS),    int'(m_ds));
    check("DLN",   int'(DLN),   int'(m_dln));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_conv(input string name, input logic [15:0] d, input logic [12:0] y,
                          input int lat, input int dl, input int ds, input int dln,
                          input bit chk_ready);
    int n;
    start = 1'b1; D = d; Y = y;
    step();
    start = 1'b0;
    n = 1;
    if (chk_ready) check({name, "_ready_t1"}, int'(ready), 0);
    while (!done && n < 40) begin
      step();
      n++;
    end
    check({name, "_latency"}, n, lat);
    check({name, "_DL"},  int'(DL),  dl);
    check({name, "_DS"},  int'(DS),  ds);
    check({name, "_DLN"}, int'(DLN), dln);
    if (chk_ready) begin
      step();
      check({name, "_done_1cyc"}, int'(done), 0);
    end
  endtask

  initial begin
    int cnt;
    int n;
    reset = 1'b1; start = 1'b0; D = '0; Y = '0;
    step();
    step();
    check("reset_DL",  int'(DL), 0);
    check("reset_rdy", int'(ready), 1);
    reset = 1'b0;
    step();

    run_conv("d4000", 16'h4000, 13'd0,    2,  'h700, 0, 'h700, 1'b1);
    run_conv("d0300", 16'h0300, 13'd544,  7,  'h4C0, 0, 'h438, 1'b0);
    run_conv("dffff", 16'hFFFF, 13'h1FFF, 16, 'h000, 1, 'h801, 1'b0);
    run_conv("d8000", 16'h8000, 13'd0,    16, 'h000, 1, 'h000, 1'b0);
    run_conv("d7fff", 16'h7FFF, 13'd0,    2,  'h77F, 0, 'h77F, 1'b0);
    run_conv("d8001", 16'h8001, 13'd4,    2,  'h77F, 1, 'h77E, 1'b0);
    run_conv("dff00", 16'hFF00, 13'h1000, 8,  'h400, 1, 'h000, 1'b0);
    run_conv("d0005", 16'h0005, 13'd0,    14, 'h120, 0, 'h120, 1'b0);
    step();

    // start held high: a conversion every two cycles
    start = 1'b1; D = 16'h4000; Y = '0;
    cnt = 0;
    repeat (10) begin
      step();
      if (done) begin
        cnt++;
        check("b2b_ready_on_done", int'(ready), 1);
      end
    end
    start = 1'b0;
    check("b2b_done_count", cnt, 5);
    step();
    step();

    // start pulse during NORM must not disturb the running conversion
    start = 1'b1; D = 16'h0001; Y = 13'd4;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1; D = 16'h4000; Y = 13'd0;
    step();
    start = 1'b0;
    n = 4;
    while (!done && n < 40) begin
      step();
      n++;
    end
    check("ignore_latency", n, 16);
    check("ignore_DL",  int'(DL),  'h000);
    check("ignore_DLN", int'(DLN), 'hFFF);
    step();

    // reset in the middle of a long normalization
    start = 1'b1; D = 16'h0001; Y = '0;
    step();
    start = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_ready", int'(ready), 1);
    check("abort_done",  int'(done),  0);
    check("abort_DLN",   int'(DLN),   0);
    cnt = 0;
    repeat (20) begin
      step();
      if (done) cnt++;
    end
    check("abort_no_done", cnt, 0);
    run_conv("d2000", 16'h2000, 13'd0, 3, 'h680, 0, 'h680, 1'b0);
    step();

    // reset wins over start in the same cycle
    reset = 1'b1; start = 1'b1; D = 16'h4000;
    step();
    reset = 1'b0; start = 1'b0;
    step();
    step();
    check("rst_vs_start_done", int'(done), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
